// File: rtl/regfile_pkg.sv
// Shared defaults and index type for the RV32 register file with busy scoreboard.
package regfile_pkg;
  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  typedef logic [4:0] reg_idx_t;
endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: write-first bypass over the flop storage and busy lookup.
module register_file_read_port #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic [NREGS-1:0][XLEN-1:0] data,
  input  logic [NREGS-1:0]           busy,
  input  logic                       wr_ena,
  input  logic [AW-1:0]              wr_addr,
  input  logic [XLEN-1:0]            wr_data,
  input  logic [AW-1:0]              rd_addr,
  output logic [XLEN-1:0]            rd_data,
  output logic                       rd_busy
);
  logic wr_hit;
  logic is_zero;

  assign wr_hit  = wr_ena && (wr_addr == rd_addr);
  assign is_zero = ZERO_REG && (rd_addr == '0);

  always_comb begin
    rd_data = data[rd_addr];
    if (is_zero)
      rd_data = '0;
    else if (wr_hit)
      rd_data = wr_data;
  end

  // A writeback in flight this cycle already satisfies the pending write.
  assign rd_busy = busy[rd_addr] && !wr_hit;
endmodule

// File: rtl/register_file_scoreboard.sv
// Flop register file with N combinational read ports, one write port and a busy scoreboard.
module register_file_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int N_READ   = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(NREGS),
  localparam int CW      = $clog2(NREGS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_ena,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic [N_READ*AW-1:0]   rd_addr,
  output logic [N_READ*XLEN-1:0] rd_data,
  output logic [N_READ-1:0]      rd_busy,
  input  logic                   issue_ena,
  input  logic [AW-1:0]          issue_addr,
  output logic                   issue_ready,
  input  logic                   flush,
  output logic [CW-1:0]          pending_count
);
  logic [NREGS-1:0][XLEN-1:0] data_reg;
  logic [NREGS-1:0]           busy_reg;
  logic [NREGS-1:0]           busy_next;
  logic [CW-1:0]              count_reg;
  logic [CW-1:0]              count_next;
  logic                       issue_acc;

  // issue_ready is independent of issue_ena, so acceptance cannot loop back.
  assign issue_ready = (ZERO_REG && (issue_addr == '0)) || !busy_reg[issue_addr] ||
                       (wr_ena && (wr_addr == issue_addr));
  assign issue_acc   = issue_ena && issue_ready && !flush;

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    if (ZERO_REG && gi == 0) begin : g_zero
      assign busy_next[gi] = 1'b0;
      always_ff @(posedge clk) begin
        data_reg[gi] <= '0;
        busy_reg[gi] <= 1'b0;
      end
    end else begin : g_live
      always_comb begin
        busy_next[gi] = busy_reg[gi];
        if (flush)
          busy_next[gi] = 1'b0;
        else if (issue_acc && (issue_addr == AW'(gi)))
          busy_next[gi] = 1'b1;
        else if (wr_ena && (wr_addr == AW'(gi)))
          busy_next[gi] = 1'b0;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg[gi] <= '0;
          busy_reg[gi] <= 1'b0;
        end else begin
          busy_reg[gi] <= busy_next[gi];
          if (wr_ena && (wr_addr == AW'(gi)))
            data_reg[gi] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    count_next = '0;
    for (int i = 0; i < NREGS; i++)
      count_next = count_next + CW'(busy_next[i]);
  end

  always_ff @(posedge clk) begin
    if (rst)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  assign pending_count = count_reg;

  for (genvar gi = 0; gi < N_READ; gi++) begin : g_rd
    register_file_read_port #(
      .XLEN     (XLEN),
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .data    (data_reg),
      .busy    (busy_reg),
      .wr_ena  (wr_ena),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr[gi*AW +: AW]),
      .rd_data (rd_data[gi*XLEN +: XLEN]),
      .rd_busy (rd_busy[gi])
    );
  end
endmodule

// File: doc/register_file_scoreboard.md
# register_file_scoreboard

Parametrised successor to the RV32 register file: flop-based storage with a configurable number of combinational read ports, one write port, and write-to-read bypass. It adds a synchronous reset and a per-register busy scoreboard, which lets the pipeline's decode stage detect RAW and WAW hazards on registers with outstanding writebacks. It sits between decode (issue, reads) and writeback (write).

## Interface
- `XLEN`, default 32: data width.
- `NREGS`, default 32: register count, power of two, ≥ 2; `AW = $clog2(NREGS)`.
- `N_READ`, default 2: number of read ports, 1–4.
- `ZERO_REG`, default 1: when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_ena`  in  1  writeback strobe.
- `wr_addr`  in  AW  writeback register index.
- `wr_data`  in  XLEN  writeback data.
- `rd_addr`  in  N_READ×AW  read indices, packed, port i = bits [i*AW +: AW].
- `rd_data`  out  N_READ×XLEN  read data, packed the same way.
- `rd_busy`  out  N_READ  port i's register has a pending write not satisfied this cycle.
- `issue_ena`  in  1  decode requests to reserve `issue_addr` as a destination.
- `issue_addr`  in  AW  destination index.
- `issue_ready`  out  1  reservation can be accepted this cycle.
- `flush`  in  1  drop all reservations (pipeline squash).
- `pending_count`  out  $clog2(NREGS+1)  number of busy registers.

## Operation
- Storage: NREGS×XLEN flops, no inferred RAM. `rst` clears all data to 0, all busy bits to 0, and `pending_count` to 0.
- Write: when `wr_ena`, data[wr_addr] ← wr_data and busy[wr_addr] ← 0. This is ignored for index 0 when ZERO_REG=1.
- Write to a non-busy register is legal: data is updated and busy stays 0.
- Read port i, combinational:
  - index 0 with ZERO_REG=1 → 0;
  - otherwise, if `wr_ena` and `wr_addr == rd_addr[i]` → `wr_data` (write-first bypass);
  - otherwise → data[rd_addr[i]].
- `rd_busy[i]` = busy[rd_addr[i]] AND NOT (`wr_ena` AND `wr_addr == rd_addr[i]`).
- `issue_ready` = NOT busy[issue_addr] OR (`wr_ena` AND `wr_addr == issue_addr`). It is always 1 for index 0 when ZERO_REG=1.
- Issue accepted = `issue_ena` AND `issue_ready` AND NOT `flush`. Acceptance sets busy[issue_addr] ← 1; index 0 is never set.
- Write and accepted issue to the same index in one cycle: the data is written and busy ends at 1, because issue wins.
- `flush`: all busy bits ← 0 next edge. Data is unaffected and a same-cycle write still lands. Flush beats issue.
- `pending_count` = popcount of busy bits, registered alongside them. Priority for each edge: `rst` > `flush` > normal.

## Timing
- Reads: zero latency, combinational from `rd_addr`, `wr_*` and state.
- Write visible in storage one cycle after `wr_ena`, and in the same cycle via bypass.
- Busy set visible on `rd_busy`/`issue_ready` the cycle after acceptance; cleared in the writeback cycle itself via the bypass terms.
- `issue_ready` does not depend on `issue_ena`, so there is no combinational loop.
- `rst` mid-operation discards pending reservations and data in one edge. All outputs are valid the following cycle: `rd_data` = 0, `rd_busy` = 0, `issue_ready` = 1.

## Structure
- Package `regfile_pkg`: `XLEN_DEFAULT`, `NREGS_DEFAULT`, and `typedef logic [4:0] reg_idx_t` for RV32.
- Sub-module `register_file_read_port`: one per read port via generate. It takes the full data/busy vectors plus the write-bypass inputs and produces `rd_data[i]` and `rd_busy[i]`.
- Storage and busy vectors are written out with generate loops, one always_ff per register, never as an unpacked-array RAM.

## Test plan
- **Reset and x0.** Reset, then write 0xDEADBEEF to x0 → `rd_data` of x0 = 0, `pending_count` = 0; all ports read 0 after reset.
- **Bypass.** Write 0x12345678 to x5 with port 0 on x5 in the same cycle → port 0 = 0x12345678 that cycle and the next.
- **Scoreboard RAW.** Issue x7 → next cycle `rd_busy[1]` = 1 on x7 and `pending_count` = 1. Writeback 0xA5 to x7 → `rd_busy[1]` = 0 in that cycle, data = 0xA5, `pending_count` = 0 next cycle.
- **WAW and same-cycle ops.** With x3 busy, `issue_ready` = 0 for x3. Write x3 and issue x3 in the same cycle → `issue_ready` = 1, busy stays 1, `pending_count` unchanged.
- **Flush.** Issue x1, x2, x4 → `pending_count` = 3. Assert `flush` together with `issue_ena` on x9 → all busy = 0, x9 not busy, count = 0.
- **Parametric.** NREGS=16, XLEN=64, N_READ=3, ZERO_REG=0: write 0xFFFF_0000_0000_0001 to x0 → it reads back on all three ports.
